// File: rtl/sid_regfile_pkg.sv
// Shared address map and voice decode for the 8580 SID register file.
package sid_regfile_pkg;

    localparam logic [2:0] REG_FREQ_LO = 3'd0;
    localparam logic [2:0] REG_FREQ_HI = 3'd1;
    localparam logic [2:0] REG_PW_LO   = 3'd2;
    localparam logic [2:0] REG_PW_HI   = 3'd3;
    localparam logic [2:0] REG_CONTROL = 3'd4;
    localparam logic [2:0] REG_ATT_DEC = 3'd5;
    localparam logic [2:0] REG_SUS_REL = 3'd6;

    localparam logic [4:0] VOICE_STRIDE = 5'd7;
    localparam logic [4:0] VOICE1_BASE  = 5'd7;
    localparam logic [4:0] VOICE2_BASE  = 5'd14;
    localparam logic [4:0] VOICE_END    = 5'd21;

    localparam logic [4:0] REG_FC_LO    = 5'h15;
    localparam logic [4:0] REG_FC_HI    = 5'h16;
    localparam logic [4:0] REG_RES_FILT = 5'h17;
    localparam logic [4:0] REG_MODE_VOL = 5'h18;
    localparam logic [4:0] REG_POTX     = 5'h19;
    localparam logic [4:0] REG_POTY     = 5'h1A;
    localparam logic [4:0] REG_OSC3     = 5'h1B;
    localparam logic [4:0] REG_ENV3     = 5'h1C;

    typedef struct packed {
        logic       is_voice;
        logic [1:0] voice;
        logic [2:0] offset;
    } voice_sel_t;

    // Split a bus address into voice index and per-voice register offset.
    function automatic voice_sel_t voice_sel(input logic [4:0] a);
        voice_sel_t s;
        s.is_voice = 1'b1;
        s.voice    = 2'd0;
        s.offset   = a[2:0];
        if (a < VOICE1_BASE) begin
            s.voice  = 2'd0;
            s.offset = 3'(a);
        end else if (a < VOICE2_BASE) begin
            s.voice  = 2'd1;
            s.offset = 3'(a - VOICE1_BASE);
        end else if (a < VOICE_END) begin
            s.voice  = 2'd2;
            s.offset = 3'(a - VOICE2_BASE);
        end else begin
            s.is_voice = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// SID data-bus latch; decay to zero is built only when SID_BUS_DECAY_EN is defined.
module sid_bus_latch #(
    parameter logic [23:0] DECAY_CYCLES = 24'd663552
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ce_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] latch_o
);

    logic [7:0] latch_q, latch_d;

`ifdef SID_BUS_DECAY_EN
    logic [23:0] cnt_q, cnt_d;

    // Load wins over decay; the latch clears on the tick the count reaches the limit.
    always_comb begin
        latch_d = latch_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            latch_d = load_val_i;
            cnt_d   = 24'd0;
        end else if (ce_i) begin
            if (cnt_q != DECAY_CYCLES) begin
                cnt_d = cnt_q + 24'd1;
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_d == DECAY_CYCLES) begin
                latch_d = 8'h00;
            end else begin
                latch_d = latch_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Decay counter state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_decay_s;
    assign unused_decay_s = ce_i ^ (^DECAY_CYCLES);

    // Without decay the latch simply holds its last loaded value.
    always_comb begin
        if (load_i) begin
            latch_d = load_val_i;
        end else begin
            latch_d = latch_q;
        end
    end
`endif

    // Latch state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= 8'h00;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign latch_o = latch_q;

endmodule

// File: rtl/sid_regfile_8580.sv
// 8580 SID CPU-bus register file: write decode, readable registers, bus latch.
// Bus-latch decay is enabled by defining SID_BUS_DECAY_EN.
module sid_regfile_8580 import sid_regfile_pkg::*; #(
    parameter logic [23:0] DECAY_CYCLES = 24'd663552
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce_1m,
    input  logic        cs,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [23:0] freq_lo,
    output logic [23:0] freq_hi,
    output logic [23:0] pw_lo,
    output logic [11:0] pw_hi,
    output logic [23:0] control,
    output logic [23:0] att_dec,
    output logic [23:0] sus_rel,
    output logic [2:0]  fc_lo,
    output logic [7:0]  fc_hi,
    output logic [7:0]  res_filt,
    output logic [7:0]  mode_vol,
    input  logic [7:0]  osc3,
    input  logic [7:0]  env3,
    input  logic [7:0]  pot_x,
    input  logic [7:0]  pot_y
);

    logic [23:0] freq_lo_q, freq_lo_d, freq_hi_q, freq_hi_d, pw_lo_q, pw_lo_d;
    logic [23:0] control_q, control_d, att_dec_q, att_dec_d, sus_rel_q, sus_rel_d;
    logic [11:0] pw_hi_q, pw_hi_d;
    logic [2:0]  fc_lo_q, fc_lo_d;
    logic [7:0]  fc_hi_q, fc_hi_d, res_filt_q, res_filt_d, mode_vol_q, mode_vol_d;
    logic [7:0]  data_out_q, data_out_d;

    logic        wr_s, rd_s, rd_hit_s, latch_load_s;
    logic [7:0]  rd_val_s, latch_val_s, latch_s;
    voice_sel_t  vs_s;

    assign wr_s = ce_1m & cs & we;
    assign rd_s = ce_1m & cs & ~we;
    assign vs_s = voice_sel(addr);

    // Write decode into the voice and filter registers.
    always_comb begin
        freq_lo_d  = freq_lo_q;
        freq_hi_d  = freq_hi_q;
        pw_lo_d    = pw_lo_q;
        pw_hi_d    = pw_hi_q;
        control_d  = control_q;
        att_dec_d  = att_dec_q;
        sus_rel_d  = sus_rel_q;
        fc_lo_d    = fc_lo_q;
        fc_hi_d    = fc_hi_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        if (wr_s && vs_s.is_voice) begin
            case (vs_s.offset)
                REG_FREQ_LO: freq_lo_d[{vs_s.voice, 3'b000} +: 8] = data_in;
                REG_FREQ_HI: freq_hi_d[{vs_s.voice, 3'b000} +: 8] = data_in;
                REG_PW_LO:   pw_lo_d[{vs_s.voice, 3'b000} +: 8]   = data_in;
                REG_PW_HI:   pw_hi_d[{vs_s.voice, 2'b00} +: 4]    = data_in[3:0];
                REG_CONTROL: control_d[{vs_s.voice, 3'b000} +: 8] = data_in;
                REG_ATT_DEC: att_dec_d[{vs_s.voice, 3'b000} +: 8] = data_in;
                REG_SUS_REL: sus_rel_d[{vs_s.voice, 3'b000} +: 8] = data_in;
                default:     freq_lo_d = freq_lo_q;
            endcase
        end else if (wr_s) begin
            case (addr)
                REG_FC_LO:    fc_lo_d    = data_in[2:0];
                REG_FC_HI:    fc_hi_d    = data_in;
                REG_RES_FILT: res_filt_d = data_in;
                REG_MODE_VOL: mode_vol_d = data_in;
                default:      fc_lo_d    = fc_lo_q;
            endcase
        end else begin
            fc_lo_d = fc_lo_q;
        end
    end

    // Read mux: readable registers feed the latch, everything else reads the latch.
    always_comb begin
        rd_hit_s = 1'b1;
        case (addr)
            REG_POTX: rd_val_s = pot_x;
            REG_POTY: rd_val_s = pot_y;
            REG_OSC3: rd_val_s = osc3;
            REG_ENV3: rd_val_s = env3;
            default: begin
                rd_val_s = latch_s;
                rd_hit_s = 1'b0;
            end
        endcase
        if (rd_s) begin
            data_out_d = rd_val_s;
        end else begin
            data_out_d = data_out_q;
        end
        if (wr_s) begin
            latch_val_s = data_in;
        end else begin
            latch_val_s = rd_val_s;
        end
    end

    assign latch_load_s = wr_s | (rd_s & rd_hit_s);

    sid_bus_latch #(
        .DECAY_CYCLES (DECAY_CYCLES)
    ) u_bus_latch (
        .clock      (clock),
        .reset_n    (reset_n),
        .ce_i       (ce_1m),
        .load_i     (latch_load_s),
        .load_val_i (latch_val_s),
        .latch_o    (latch_s)
    );

    // Register state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freq_lo_q  <= 24'h0;
            freq_hi_q  <= 24'h0;
            pw_lo_q    <= 24'h0;
            pw_hi_q    <= 12'h0;
            control_q  <= 24'h0;
            att_dec_q  <= 24'h0;
            sus_rel_q  <= 24'h0;
            fc_lo_q    <= 3'h0;
            fc_hi_q    <= 8'h0;
            res_filt_q <= 8'h0;
            mode_vol_q <= 8'h0;
            data_out_q <= 8'h0;
        end else begin
            freq_lo_q  <= freq_lo_d;
            freq_hi_q  <= freq_hi_d;
            pw_lo_q    <= pw_lo_d;
            pw_hi_q    <= pw_hi_d;
            control_q  <= control_d;
            att_dec_q  <= att_dec_d;
            sus_rel_q  <= sus_rel_d;
            fc_lo_q    <= fc_lo_d;
            fc_hi_q    <= fc_hi_d;
            res_filt_q <= res_filt_d;
            mode_vol_q <= mode_vol_d;
            data_out_q <= data_out_d;
        end
    end

    assign freq_lo  = freq_lo_q;
    assign freq_hi  = freq_hi_q;
    assign pw_lo    = pw_lo_q;
    assign pw_hi    = pw_hi_q;
    assign control  = control_q;
    assign att_dec  = att_dec_q;
    assign sus_rel  = sus_rel_q;
    assign fc_lo    = fc_lo_q;
    assign fc_hi    = fc_hi_q;
    assign res_filt = res_filt_q;
    assign mode_vol = mode_vol_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_sid_regfile_8580.sv
// Directed self-checking bench for sid_regfile_8580 (decay case uses DECAY_CYCLES=16).
module tb_sid_regfile_8580;

    logic        clock = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset_n = 1'b0;
    logic        ce_1m = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'h00;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic [23:0] freq_lo, freq_hi, pw_lo, control, att_dec, sus_rel;
    logic [11:0] pw_hi;
    logic [2:0]  fc_lo;
    logic [7:0]  fc_hi, res_filt, mode_vol;
    logic [7:0]  osc3 = 8'h00;
    logic [7:0]  env3 = 8'h00;
    logic [7:0]  pot_x = 8'h00;
    logic [7:0]  pot_y = 8'h00;

    int total = 0;
    int bad = 0;

    sid_regfile_8580 #(.DECAY_CYCLES(24'd16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ce_1m    (ce_1m),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .freq_lo  (freq_lo),
        .freq_hi  (freq_hi),
        .pw_lo    (pw_lo),
        .pw_hi    (pw_hi),
        .control  (control),
        .att_dec  (att_dec),
        .sus_rel  (sus_rel),
        .fc_lo    (fc_lo),
        .fc_hi    (fc_hi),
        .res_filt (res_filt),
        .mode_vol (mode_vol),
        .osc3     (osc3),
        .env3     (env3),
        .pot_x    (pot_x),
        .pot_y    (pot_y)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clock = ~clock;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One strobed bus cycle; returns #1 after the strobe edge.
    task automatic bus(input logic w, input logic [4:0] a, input logic [7:0] d);
        ce_1m = 1'b1; cs = 1'b1; we = w; addr = a; data_in = d;
        @(posedge clock); #1;
        ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ce_1m = 1'b1; cs = 1'b0;
            @(posedge clock); #1;
            ce_1m = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_control",  32'(control),  32'h0);
        check("rst_freq_lo",  32'(freq_lo),  32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        bus(1'b1, 5'h0B, 8'h12);
        check("v2_control", 32'(control), 32'h001200);
        bus(1'b1, 5'h0A, 8'hAB);
        check("v2_pw_hi", 32'(pw_hi), 32'h0B0);
        bus(1'b1, 5'h0F, 8'h0F);
        check("v3_freq_hi", 32'(freq_hi), 32'h0F0000);
        bus(1'b1, 5'h15, 8'hFF);
        check("fc_lo", 32'(fc_lo), 32'h7);
        bus(1'b1, 5'h18, 8'h9C);
        check("mode_vol", 32'(mode_vol), 32'h9C);
        bus(1'b1, 5'h1F, 8'h44);
        check("unmapped_wr_ctrl", 32'(control), 32'h001200);
        check("unmapped_wr_mv",   32'(mode_vol), 32'h9C);
        check("wr_keeps_dout",    32'(data_out), 32'h0);
        bus(1'b0, 5'h00, 8'h00);
        check("latch_1f", 32'(data_out), 32'h44);

        // Asynchronous reset with the clock frozen.
        clk_en = 1'b0;
        #3 reset_n = 1'b0;
        #2;
        check("arst_control",  32'(control),  32'h0);
        check("arst_pw_hi",    32'(pw_hi),    32'h0);
        check("arst_data_out", 32'(data_out), 32'h0);
        #2 reset_n = 1'b1;
        #1 clk_en = 1'b1;
        bus(1'b0, 5'h00, 8'h00);
        check("post_rst_read", 32'(data_out), 32'h0);

        bus(1'b1, 5'h04, 8'h5A);
        check("v1_control", 32'(control), 32'h00005A);
        bus(1'b0, 5'h04, 8'h00);
        check("rd_wo_04", 32'(data_out), 32'h5A);
        bus(1'b0, 5'h1D, 8'h00);
        check("rd_1d", 32'(data_out), 32'h5A);

        osc3 = 8'hC3; env3 = 8'h7E; pot_x = 8'h11; pot_y = 8'h22;
        bus(1'b0, 5'h1B, 8'h00);
        check("rd_osc3", 32'(data_out), 32'hC3);
        bus(1'b0, 5'h1C, 8'h00);
        check("rd_env3", 32'(data_out), 32'h7E);
        bus(1'b0, 5'h00, 8'h00);
        check("latch_env3", 32'(data_out), 32'h7E);
        bus(1'b0, 5'h19, 8'h00);
        check("rd_potx", 32'(data_out), 32'h11);
        bus(1'b0, 5'h1A, 8'h00);
        check("rd_poty", 32'(data_out), 32'h22);
        bus(1'b0, 5'h10, 8'h00);
        check("latch_poty", 32'(data_out), 32'h22);

`ifdef SID_BUS_DECAY_EN
        bus(1'b1, 5'h1E, 8'h33);
        idle_ticks(15);
        bus(1'b0, 5'h00, 8'h00);
        check("decay_edge", 32'(data_out), 32'h33);
        idle_ticks(1);
        bus(1'b0, 5'h00, 8'h00);
        check("decay_zero", 32'(data_out), 32'h00);
        bus(1'b1, 5'h1E, 8'h66);
        idle_ticks(15);
        bus(1'b1, 5'h1E, 8'h77);
        idle_ticks(15);
        bus(1'b0, 5'h00, 8'h00);
        check("decay_restart", 32'(data_out), 32'h77);
        idle_ticks(1);
        bus(1'b0, 5'h00, 8'h00);
        check("decay_restart0", 32'(data_out), 32'h00);
`else
        bus(1'b1, 5'h1E, 8'h33);
        idle_ticks(1000);
        bus(1'b0, 5'h00, 8'h00);
        check("no_decay", 32'(data_out), 32'h33);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
